// File: rtl/subtract_mean_hls_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module   : subtract_mean_hls_deadlock_pkg
// Brief    : Shared types and constants for the deadlock report controller.
// Revision : 1.0 - initial release
// ============================================================================
package subtract_mean_hls_deadlock_pkg;

  localparam int unsigned C_NUM_MON_DEF = 4;
  localparam int unsigned C_THRESH_DEF  = 16;
  localparam int unsigned C_STAMP_W     = 32;
  localparam int unsigned C_CNT_W       = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WATCH   = 3'd1,
    CONFIRM = 3'd2,
    REPORT  = 3'd3,
    HALT    = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/subtract_mean_hls_deadlock_prio_enc.sv
`default_nettype none
// ============================================================================
// Module   : subtract_mean_hls_deadlock_prio_enc
// Brief    : Combinational lowest-index-first priority encoder.
// Revision : 1.0 - initial release
// ============================================================================
module subtract_mean_hls_deadlock_prio_enc #(
  parameter int NUM_MON = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_MON-1:0] req_i,
  output logic               any_o,
  output logic [IDX_W-1:0]   idx_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = IDX_W'(i);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/subtract_mean_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : subtract_mean_hls_deadlock_report_ctrl
// Brief    : Confirms a persistent monitor block flag as a deadlock, stamps
//            it with a free-running cycle count and hands one record out.
// Revision : 1.0 - initial release
// ============================================================================
module subtract_mean_hls_deadlock_report_ctrl
  import subtract_mean_hls_deadlock_pkg::*;
#(
  parameter int NUM_MON = C_NUM_MON_DEF,
  parameter int THRESH  = C_THRESH_DEF,
  parameter int IDX_W   = $clog2(NUM_MON)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [NUM_MON-1:0]   mon_block,
  output logic                 report_valid,
  input  logic                 report_ready,
  output logic [IDX_W-1:0]     report_idx,
  output logic [C_STAMP_W-1:0] report_stamp,
  output logic                 deadlock
);

  // Last count value before confirmation; reaching it with the flag still
  // high makes the THRESH-th consecutive sample.
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(THRESH - 1);

  state_e               state_q, state_d;
  logic [C_CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]     cand_q, cand_d;
  logic [C_STAMP_W-1:0] stamp_q;
  logic                 valid_q, valid_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [C_STAMP_W-1:0] rstamp_q, rstamp_d;
  logic                 dl_q, dl_d;

  logic                 enc_any;
  logic [IDX_W-1:0]     enc_idx;

  subtract_mean_hls_deadlock_prio_enc #(
    .NUM_MON (NUM_MON),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req_i (mon_block),
    .any_o (enc_any),
    .idx_o (enc_idx)
  );

  // Free-running confirmation timestamp, wraps silently.
  always_ff @(posedge clock) begin
    if (reset) begin
      stamp_q <= '0;
    end else begin
      stamp_q <= stamp_q + 32'd1;
    end
  end

  // Next-state and record logic; clear outranks every other transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    cand_d   = cand_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    rstamp_d = rstamp_q;
    dl_d     = dl_q;
    if (clear) begin
      valid_d = 1'b0;
      dl_d    = 1'b0;
      cnt_d   = '0;
      state_d = enable ? WATCH : IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) state_d = WATCH;
        end
        WATCH: begin
          if (!enable) begin
            state_d = IDLE;
          end else if (enc_any) begin
            cand_d  = enc_idx;
            cnt_d   = C_CNT_W'(1);
            state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (!enable) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (!mon_block[cand_q]) begin
            cnt_d   = '0;
            state_d = WATCH;
          end else if (cnt_q == C_CNT_LAST) begin
            idx_d    = cand_q;
            rstamp_d = stamp_q;
            valid_d  = 1'b1;
            dl_d     = 1'b1;
            cnt_d    = '0;
            state_d  = REPORT;
          end else begin
            cnt_d = cnt_q + C_CNT_W'(1);
          end
        end
        REPORT: begin
          if (report_ready) begin
            valid_d = 1'b0;
            state_d = HALT;
          end
        end
        HALT: begin
          state_d = HALT;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and record registers; reset discards any pending record.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      cand_q   <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      rstamp_q <= '0;
      dl_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      cand_q   <= cand_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      rstamp_q <= rstamp_d;
      dl_q     <= dl_d;
    end
  end

  assign report_valid = valid_q;
  assign report_idx   = idx_q;
  assign report_stamp = rstamp_q;
  assign deadlock     = dl_q;

endmodule
`default_nettype wire

// File: tb/tb_subtract_mean_hls_deadlock_report_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_subtract_mean_hls_deadlock_report_ctrl
// Brief    : Self-checking bench: directed table, corner sequences and a
//            randomized run against a behavioural reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_subtract_mean_hls_deadlock_report_ctrl;
  import subtract_mean_hls_deadlock_pkg::*;

  localparam int NUM_MON = 4;
  localparam int THRESH  = 4;
  localparam int IDX_W   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               enable;
  logic               clear;
  logic [NUM_MON-1:0] mon_block;
  logic               report_valid;
  logic               report_ready;
  logic [IDX_W-1:0]   report_idx;
  logic [31:0]        report_stamp;
  logic               deadlock;

  int n_checks = 0;
  int n_pass   = 0;

  subtract_mean_hls_deadlock_report_ctrl #(
    .NUM_MON (NUM_MON),
    .THRESH  (THRESH),
    .IDX_W   (IDX_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .mon_block    (mon_block),
    .report_valid (report_valid),
    .report_ready (report_ready),
    .report_idx   (report_idx),
    .report_stamp (report_stamp),
    .deadlock     (deadlock)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // Behaviour phrased as "how many consecutive high samples has the
  // candidate had"; a record is produced on the THRESH-th one.
  localparam int M_IDLE = 0, M_WATCH = 1, M_CONFIRM = 2, M_REPORT = 3, M_HALT = 4;
  int          m_mode;
  int          m_cand;
  int          m_run;
  logic [31:0] m_stamp;
  logic        m_valid;
  logic [1:0]  m_idx;
  logic [31:0] m_rstamp;
  logic        m_dl;

  task automatic model_update(input logic r, input logic en, input logic clr,
                              input logic [3:0] mb, input logic rdy);
    bit found;
    if (r) begin
      m_mode = M_IDLE; m_cand = 0; m_run = 0; m_stamp = 0;
      m_valid = 0; m_idx = 0; m_rstamp = 0; m_dl = 0;
    end else begin
      if (clr) begin
        m_valid = 0; m_dl = 0; m_run = 0;
        m_mode  = en ? M_WATCH : M_IDLE;
      end else if (m_mode == M_IDLE) begin
        if (en) m_mode = M_WATCH;
      end else if (m_mode == M_WATCH) begin
        if (!en) m_mode = M_IDLE;
        else if (mb != 0) begin
          found = 0;
          for (int i = 0; i < NUM_MON; i++) begin
            if (mb[i] && !found) begin
              found  = 1;
              m_cand = i;
            end
          end
          m_run  = 1;
          m_mode = M_CONFIRM;
        end
      end else if (m_mode == M_CONFIRM) begin
        if (!en) begin
          m_run = 0; m_mode = M_IDLE;
        end else if (!mb[m_cand]) begin
          m_run = 0; m_mode = M_WATCH;
        end else begin
          m_run = m_run + 1;
          if (m_run == THRESH) begin
            m_idx = 2'(m_cand); m_rstamp = m_stamp;
            m_valid = 1; m_dl = 1; m_run = 0; m_mode = M_REPORT;
          end
        end
      end else if (m_mode == M_REPORT) begin
        if (rdy) begin
          m_valid = 0; m_mode = M_HALT;
        end
      end
      m_stamp = m_stamp + 32'd1;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Called at a negedge: drive, let one rising edge pass, return at next negedge.
  task automatic step(input logic r, input logic en, input logic clr,
                      input logic [3:0] mb, input logic rdy);
    reset = r; enable = en; clear = clr; mon_block = mb; report_ready = rdy;
    @(posedge clock);
    model_update(r, en, clr, mb, rdy);
    @(negedge clock);
  endtask

  task automatic mcheck(input string tag);
    chk({tag, ".valid"},    32'(report_valid), 32'(m_valid));
    chk({tag, ".idx"},      32'(report_idx),   32'(m_idx));
    chk({tag, ".stamp"},    report_stamp,      m_rstamp);
    chk({tag, ".deadlock"}, 32'(deadlock),     32'(m_dl));
  endtask

  task automatic chk_outs(input string tag, input logic v, input logic [1:0] ix,
                          input logic [31:0] st, input logic dl);
    chk({tag, ".valid"},    32'(report_valid), 32'(v));
    chk({tag, ".idx"},      32'(report_idx),   32'(ix));
    chk({tag, ".stamp"},    report_stamp,      st);
    chk({tag, ".deadlock"}, 32'(deadlock),     32'(dl));
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        en;
    logic        clr;
    logic [3:0]  mb;
    logic        rdy;
    logic        e_valid;
    logic [1:0]  e_idx;
    logic [31:0] e_stamp;
    logic        e_dl;
    state_e      e_state;
  } vec_t;

  vec_t vt [23];

  function automatic vec_t mk(input logic en, input logic clr, input logic [3:0] mb,
                              input logic rdy, input logic v, input logic [1:0] ix,
                              input logic [31:0] st, input logic dl, input state_e s);
    vec_t r;
    r.en = en; r.clr = clr; r.mb = mb; r.rdy = rdy;
    r.e_valid = v; r.e_idx = ix; r.e_stamp = st; r.e_dl = dl; r.e_state = s;
    return r;
  endfunction

  logic       r_rst, r_en, r_clr, r_rdy;
  logic [3:0] r_mb;

  initial begin
    // Row k drives cycle k (stamp == k); expectations are for cycle k+1.
    for (int i = 0; i < 10; i++) vt[i] = mk(1, 0, 4'b0000, 0, 0, 2'd0, 32'd0, 0, WATCH);
    for (int i = 10; i < 13; i++) vt[i] = mk(1, 0, 4'b0100, 0, 0, 2'd0, 32'd0, 0, CONFIRM);
    vt[13] = mk(1, 0, 4'b0100, 0, 1, 2'd2, 32'd13, 1, REPORT);
    for (int i = 14; i < 19; i++) vt[i] = mk(1, 0, 4'b1111, 0, 1, 2'd2, 32'd13, 1, REPORT);
    vt[19] = mk(1, 0, 4'b0000, 1, 0, 2'd2, 32'd13, 1, HALT);
    vt[20] = mk(1, 0, 4'b1111, 0, 0, 2'd2, 32'd13, 1, HALT);
    vt[21] = mk(0, 0, 4'b0101, 1, 0, 2'd2, 32'd13, 1, HALT);
    vt[22] = mk(1, 1, 4'b0000, 0, 0, 2'd2, 32'd13, 0, WATCH);

    reset = 1; enable = 0; clear = 0; mon_block = '0; report_ready = 0;
    @(negedge clock);

    // Reset state
    step(1, 0, 0, 4'b0000, 0);
    chk_outs("reset", 0, 2'd0, 32'd0, 0);
    chk("reset.state", 32'(dut.state_q), 32'(IDLE));
    chk("reset.stamp_cnt", dut.stamp_q, 32'd0);

    // Directed table: detection latency, stall in REPORT, HALT, clear
    for (int i = 0; i < 23; i++) begin
      step(0, vt[i].en, vt[i].clr, vt[i].mb, vt[i].rdy);
      chk_outs($sformatf("tbl%0d", i), vt[i].e_valid, vt[i].e_idx, vt[i].e_stamp, vt[i].e_dl);
      chk($sformatf("tbl%0d.state", i), 32'(dut.state_q), 32'(vt[i].e_state));
    end

    // Candidate drops out; next-lowest still-high bit is re-candidated
    step(1, 0, 0, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 0);              // cycle 0 -> WATCH
    step(0, 1, 0, 4'b1010, 0);              // cycle 1 -> CONFIRM on 1
    chk("recand.cand1", 32'(dut.cand_q), 32'd1);
    step(0, 1, 0, 4'b1010, 0);              // cycle 2
    step(0, 1, 0, 4'b1000, 0);              // cycle 3: bit 1 gone
    chk("recand.watch", 32'(dut.state_q), 32'(WATCH));
    step(0, 1, 0, 4'b1000, 0);              // cycle 4 -> CONFIRM on 3
    chk("recand.cand3", 32'(dut.cand_q), 32'd3);
    step(0, 1, 0, 4'b1000, 0);              // cycle 5
    step(0, 1, 0, 4'b1000, 0);              // cycle 6
    step(0, 1, 0, 4'b1000, 0);              // cycle 7: confirm
    chk_outs("recand", 1, 2'd3, 32'd7, 1);
    mcheck("recand.model");

    // Reset while a record is pending discards it, even with clear high
    step(1, 1, 1, 4'b1111, 1);
    chk_outs("rst_report", 0, 2'd0, 32'd0, 0);
    chk("rst_report.state", 32'(dut.state_q), 32'(IDLE));

    // Reset during CONFIRM with cnt=2
    step(0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 4'b0001, 0);
    step(0, 1, 0, 4'b0001, 0);
    chk("rst_confirm.cnt", 32'(dut.cnt_q), 32'd2);
    step(1, 1, 0, 4'b0001, 0);
    chk_outs("rst_confirm", 0, 2'd0, 32'd0, 0);
    chk("rst_confirm.state", 32'(dut.state_q), 32'(IDLE));
    chk("rst_confirm.stamp_cnt", dut.stamp_q, 32'd0);

    // Stamp wrap through 0xFFFFFFFF
    step(0, 1, 0, 4'b0000, 0);
    step(0, 1, 0, 4'b0000, 0);
    dut.stamp_q = 32'hFFFF_FFFD;
    m_stamp     = 32'hFFFF_FFFD;
    step(0, 1, 0, 4'b0001, 0);
    step(0, 1, 0, 4'b0001, 0);
    chk("wrap.stamp_ff", dut.stamp_q, 32'hFFFF_FFFF);
    step(0, 1, 0, 4'b0001, 0);
    chk("wrap.stamp_0", dut.stamp_q, 32'd0);
    step(0, 1, 0, 4'b0001, 0);
    chk_outs("wrap", 1, 2'd0, 32'd0, 1);
    mcheck("wrap.model");

    // Randomized run against the reference model
    step(1, 0, 0, 4'b0000, 0);
    r_mb = '0;
    for (int c = 0; c < 3000; c++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_en  = ($urandom_range(0, 9) != 0);
      r_clr = ($urandom_range(0, 39) == 0);
      r_rdy = 1'($urandom);
      if ($urandom_range(0, 5) == 0) r_mb = 4'($urandom) & 4'($urandom);
      step(r_rst, r_en, r_clr, r_mb, r_rdy);
      mcheck("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
